fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum FILL-state wait in cycles before an error is raised (legal range 1-255).
REQ-002 clk  in  1  SHALL be the single clock; all state updates on the posedge.
REQ-003 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 req  in  1  SHALL be the core's fetch request, qualified by ready.
REQ-005 pc  in  16  SHALL be the byte address of the requested instruction; pc[0] is ignored.
REQ-006 flush  in  1  SHALL be the redirect/abort strobe from the core.
REQ-007 ready  out  1  SHALL indicate a new request can be accepted.
REQ-008 instr  out  16  SHALL be the fetched instruction.
REQ-009 instr_valid  out  1  SHALL be a one-cycle pulse qualifying instr.
REQ-010 fetch_err  out  1  SHALL be a one-cycle pulse on memory timeout.
REQ-011 mem_addr  out  16  SHALL be the line address to memory, {tag,3'b000}.
REQ-012 mem_req  out  1  SHALL be the line-fetch request, held until mem_valid, flush or timeout.
REQ-013 mem_line  in  64  SHALL be the 64-bit line, bit 0 MSB; byte k at bits [8k:8k+7].
REQ-014 mem_valid  in  1  SHALL qualify mem_line for one cycle.
REQ-015 hit_count, miss_count  out  16 each  SHALL be the performance counters (see Configuration).

Function
REQ-016 One-line buffer: line[0:63], tag[15:3], line_valid.
REQ-017 States: IDLE (ready=1), FILL (mem_req=1), RESP (instr_valid=1), ERR (fetch_err=1); ready SHALL be 0 outside IDLE.
REQ-018 Acceptance: req & ready & ~flush; pc SHALL be latched into a request register at acceptance.
REQ-019 Hit (line_valid & pc[15:3]==tag): IDLE->RESP; instr_valid the cycle after acceptance (latency 1).
REQ-020 Miss: IDLE->FILL; tag<=pc[15:3]; mem_req and mem_addr driven from the next cycle.
REQ-021 FILL & mem_valid: line<=mem_line, line_valid<=1, ->RESP; instr_valid the cycle after mem_valid.
REQ-022 instr SHALL equal line[16k:16k+15], k = latched pc[2:1]; byte at even address forms instr[15:8].
REQ-023 RESP SHALL always ->IDLE; max throughput one hit per 2 cycles.
REQ-024 FILL timeout: a cycle counter cleared on FILL entry; when it reaches TIMEOUT without mem_valid, ->ERR, line_valid<=0.
REQ-025 mem_valid and timeout in the same cycle: mem_valid wins.
REQ-026 ERR SHALL last one cycle then ->IDLE; no instr_valid for the failed request.
REQ-027 flush, any state: line_valid<=0, state<=IDLE, pending request dropped.
REQ-028 flush in FILL SHALL drop mem_req the next cycle; mem_valid in the same cycle is discarded.
REQ-029 flush in RESP SHALL force instr_valid low that cycle (combinational gate).
REQ-030 flush with req in IDLE: req not accepted.
REQ-031 mem_valid outside FILL SHALL be ignored.

Reset
REQ-032 reset low SHALL immediately force: state IDLE, line_valid 0, tag 0, line 0, timeout counter 0, counters 0.
REQ-033 During and after reset, outputs SHALL be: instr 0, instr_valid 0, mem_req 0, mem_addr 0, fetch_err 0, ready 1.
REQ-034 Reset mid-FILL SHALL abandon the fetch; later mem_valid is ignored per REQ-031.

Configuration
REQ-035 Macro FETCH_PERF_CNT_EN defined: hit_count increments on each accepted hit and miss_count on each accepted miss; both saturate at 16'hFFFF and are cleared by reset or flush.
REQ-036 Macro FETCH_PERF_CNT_EN undefined: hit_count and miss_count SHALL be tied to 0 and no counter flops are synthesized.

Verification
REQ-037 Miss then hit: pc=0x0002, mem_line=0x0401_250A_1281_2D1E (mem_valid 3 cycles after mem_req) -> mem_addr=0x0000, instr=0x250A; then pc=0x0006 -> hit, instr=0x2D1E one cycle after acceptance, no mem_req.
REQ-038 Line change: pc=0x0010 after REQ-037 -> miss, mem_addr=0x0010; with mem_line=0x240A_0401_1281_2D1E, instr=0x240A.
REQ-039 Timeout, TIMEOUT=4: mem_valid never asserted -> fetch_err pulses after 4 FILL cycles; ready=1 the cycle after; next req to the same pc misses.
REQ-040 Flush in FILL, with mem_valid the same cycle -> no instr_valid, mem_req low next cycle, line_valid=0.
REQ-041 Reset asserted mid-FILL, mem_valid arrives after release -> no instr_valid and all outputs at reset values.
REQ-042 FETCH_PERF_CNT_EN defined: 1 miss plus 3 hits -> miss_count=1, hit_count=3; with the macro undefined, both read 0.

Source files
------------

// File: rtl/fetch_controller.sv
// fetch_controller: single-line instruction fetch buffer between a core and
// a 64-bit line memory. One request in flight; hits answer one cycle after
// acceptance, misses fetch the whole line and then answer.
// Optional build macro: FETCH_PERF_CNT_EN enables saturating hit/miss
// counters; without it hit_count/miss_count are constant zero.
// Line bit numbering: the memory side numbers bit 0 as the MSB; here the
// line is held as [63:0], so byte k sits in bits [63-8k -: 8].

module fetch_controller #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [15:0] pc,
    input  logic        flush,
    output logic        ready,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        fetch_err,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    input  logic [63:0] mem_line,
    input  logic        mem_valid,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Last FILL cycle index; counter starts at 0 on FILL entry.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [63:0] line_reg;
    logic [12:0] tag_reg;
    logic        line_valid_reg;
    logic [1:0]  word_sel_reg;   // latched pc[2:1]: the only request bits needed after acceptance
    logic [7:0]  tmo_cnt_reg;

    logic        accept;
    logic        hit;
    logic        mem_done;
    logic        timed_out;
    logic [15:0] line_words [4];

    // pc[0] selects a byte inside a 16-bit instruction and is not used.
    logic unused_pc_bit;
    assign unused_pc_bit = pc[0];

    assign accept    = ready & req & ~flush;
    assign hit       = line_valid_reg & (pc[15:3] == tag_reg);
    assign mem_done  = (state_reg == S_FILL) & mem_valid & ~flush;
    // mem_valid takes priority over an expiring counter.
    assign timed_out = (state_reg == S_FILL) & ~mem_valid & (tmo_cnt_reg == TMO_LAST);

    // Split the line into its four instruction words, word 0 = most significant.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_words
            assign line_words[gi] = line_reg[63 - 16*gi -: 16];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: if (accept) state_next = hit ? S_RESP : S_FILL;
                S_FILL: begin
                    if (mem_valid)      state_next = S_RESP;
                    else if (timed_out) state_next = S_ERR;
                end
                S_RESP:  state_next = S_IDLE;
                S_ERR:   state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Output decode from the current state.
    always_comb begin
        ready       = (state_reg == S_IDLE);
        mem_req     = (state_reg == S_FILL);
        mem_addr    = mem_req ? {tag_reg, 3'b000} : 16'h0000;
        fetch_err   = (state_reg == S_ERR);
        instr_valid = (state_reg == S_RESP) & ~flush;
        instr       = instr_valid ? line_words[word_sel_reg] : 16'h0000;
    end

    // Line buffer, tag, validity and request latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_reg       <= '0;
            tag_reg        <= '0;
            line_valid_reg <= 1'b0;
            word_sel_reg   <= '0;
        end else if (flush) begin
            line_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                word_sel_reg <= pc[2:1];
                if (!hit) begin
                    tag_reg        <= pc[15:3];
                    line_valid_reg <= 1'b0;
                end
            end
            if (mem_done) begin
                line_reg       <= mem_line;
                line_valid_reg <= 1'b1;
            end
            if (timed_out) line_valid_reg <= 1'b0;
        end
    end

    // FILL wait counter: held at zero outside FILL so every entry starts fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   tmo_cnt_reg <= '0;
        else if (state_reg != S_FILL) tmo_cnt_reg <= '0;
        else                          tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] hit_cnt_reg;
    logic [15:0] miss_cnt_reg;

    // Saturating hit/miss counters, cleared by reset or flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (flush) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (accept) begin
            if (hit) begin
                if (hit_cnt_reg != 16'hFFFF) hit_cnt_reg <= hit_cnt_reg + 16'd1;
            end else begin
                if (miss_cnt_reg != 16'hFFFF) miss_cnt_reg <= miss_cnt_reg + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_reg;
    assign miss_count = miss_cnt_reg;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios followed by random traffic.
// A reference model of the one-line buffer predicts each response and pushes
// it into a scoreboard queue; an independent monitor pops and compares every
// instr_valid / fetch_err pulse the DUT produces.

module tb_fetch_controller;

    localparam int TO = 4;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [15:0] pc;
    logic        flush;
    logic        ready;
    logic [15:0] instr;
    logic        instr_valid;
    logic        fetch_err;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic [63:0] mem_line;
    logic        mem_valid;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    fetch_controller #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .pc         (pc),
        .flush      (flush),
        .ready      (ready),
        .instr      (instr),
        .instr_valid(instr_valid),
        .fetch_err  (fetch_err),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_line   (mem_line),
        .mem_valid  (mem_valid),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [15:0] instr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model of the buffer contents and counters.
    bit          m_valid;
    logic [12:0] m_tag;
    logic [63:0] m_line;
    int          m_hits;
    int          m_misses;

    // Instruction k of a line: k=0 is the most significant 16 bits.
    function automatic logic [15:0] word_of(input logic [63:0] ln, input int k);
        return 16'(ln >> (48 - 16 * k));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_counts();
        chk("hit_count", 32'(hit_count), PERF ? m_hits : 0);
        chk("miss_count", 32'(miss_count), PERF ? m_misses : 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_instr"}, 32'(instr), 0);
        chk({tag, "_instr_valid"}, 32'(instr_valid), 0);
        chk({tag, "_mem_req"}, 32'(mem_req), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_fetch_err"}, 32'(fetch_err), 0);
        chk({tag, "_ready"}, 32'(ready), 1);
        chk_counts();
    endtask

    // Monitor: every response pulse must match the oldest predicted response.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            #4;
            if (instr_valid === 1'b1 || fetch_err === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output instr_valid=%b fetch_err=%b instr=%h required=none",
                             instr_valid, fetch_err, instr);
                end else begin
                    e = sb_q.pop_front();
                    if (e.is_err) ok = (fetch_err === 1'b1) && (instr_valid === 1'b0);
                    else          ok = (instr_valid === 1'b1) && (fetch_err === 1'b0) && (instr === e.instr);
                    if (!ok) begin
                        errors++;
                        $display("FAIL scoreboard actual: valid=%b err=%b instr=%h required: err=%b instr=%h",
                                 instr_valid, fetch_err, instr, e.is_err, e.instr);
                    end
                end
            end
        end
    end

    // mode: 0 normal, 1 memory never answers, 2 flush in FILL together with
    // mem_valid, 3 flush during the response cycle. lat = FILL cycles before mem_valid.
    task automatic fetch(input logic [15:0] a, input int lat, input int mode_in, input logic [63:0] data);
        bit   hit;
        int   k;
        int   mode;
        exp_t e;
        hit  = m_valid && (a[15:3] == m_tag);
        k    = int'(a[2:1]);
        mode = mode_in;
        if (hit && (mode == 1 || mode == 2)) mode = 0;
        $display("txn %0d pc=%h %s mode=%0d lat=%0d", txn, a, hit ? "hit" : "miss", mode, lat);
        txn++;
        @(negedge clk);
        req = 1'b1; pc = a; flush = 1'b0; mem_valid = 1'b0;
        if (hit) begin
            if (m_hits < 65535) m_hits++;
            if (mode != 3) begin
                e.is_err = 1'b0; e.instr = word_of(m_line, k); sb_q.push_back(e);
            end
        end else begin
            if (m_misses < 65535) m_misses++;
            m_tag = a[15:3]; m_valid = 1'b0;
            if (mode == 0) begin
                m_line = data; m_valid = 1'b1;
                e.is_err = 1'b0; e.instr = word_of(data, k); sb_q.push_back(e);
            end else if (mode == 1) begin
                e.is_err = 1'b1; e.instr = 16'h0; sb_q.push_back(e);
            end else if (mode == 3) begin
                m_line = data;
            end
        end
        if (mode == 2 || mode == 3) begin
            m_valid = 1'b0; m_hits = 0; m_misses = 0;
        end
        #4; chk("ready_idle", 32'(ready), 1);
        if (hit) begin
            @(negedge clk);
            req = 1'b0; pc = 16'($urandom);
            if (mode == 3) flush = 1'b1;
            #4;
            chk("hit_instr_valid", 32'(instr_valid), (mode == 3) ? 0 : 1);
            chk("hit_no_mem_req", 32'(mem_req), 0);
        end else if (mode == 1) begin
            for (int c = 1; c <= TO; c++) begin
                @(negedge clk);
                req = 1'b0; pc = 16'($urandom);
                #4;
                chk("fill_mem_req", 32'(mem_req), 1);
                chk("fill_mem_addr", 32'(mem_addr), 32'({a[15:3], 3'b000}));
            end
            @(negedge clk);
            #4;
            chk("timeout_err", 32'(fetch_err), 1);
            chk("err_not_ready", 32'(ready), 0);
        end else begin
            for (int c = 1; c <= lat + 1; c++) begin
                @(negedge clk);
                req = 1'b0; pc = 16'($urandom);
                if (c == lat + 1) begin
                    mem_valid = 1'b1; mem_line = data;
                    if (mode == 2) flush = 1'b1;
                end
                #4;
                chk("fill_mem_req", 32'(mem_req), 1);
                chk("fill_mem_addr", 32'(mem_addr), 32'({a[15:3], 3'b000}));
            end
            @(negedge clk);
            mem_valid = 1'b0; mem_line = {$urandom, $urandom}; flush = (mode == 3);
            #4;
            if (mode == 2) begin
                chk("flush_fill_drop", 32'(mem_req), 0);
                chk("flush_fill_ready", 32'(ready), 1);
            end
            chk("fill_instr_valid", 32'(instr_valid), (mode == 0) ? 1 : 0);
        end
        @(negedge clk);
        req = 1'b0; flush = 1'b0; mem_valid = 1'b0;
        #4;
        chk("back_idle", 32'(ready), 1);
        chk_counts();
    endtask

    // Request coinciding with flush in IDLE must be refused.
    task automatic flush_idle_req(input logic [15:0] a);
        $display("txn %0d pc=%h flush_with_req", txn, a);
        txn++;
        @(negedge clk);
        req = 1'b1; flush = 1'b1; pc = a; mem_valid = 1'b0;
        m_valid = 1'b0; m_hits = 0; m_misses = 0;
        #4; chk("flushreq_ready", 32'(ready), 1);
        @(negedge clk);
        req = 1'b0; flush = 1'b0;
        #4;
        chk("flushreq_not_taken", 32'(ready), 1);
        chk("flushreq_no_mem_req", 32'(mem_req), 0);
        chk_counts();
    endtask

    // mem_valid while idle must be ignored.
    task automatic idle_noise();
        $display("txn %0d idle mem_valid noise", txn);
        txn++;
        @(negedge clk);
        req = 1'b0; mem_valid = 1'b1; mem_line = {$urandom, $urandom};
        #4;
        chk("noise_ready", 32'(ready), 1);
        chk("noise_no_mem_req", 32'(mem_req), 0);
    endtask

    task automatic reset_mid_fill(input logic [15:0] a);
        $display("txn %0d pc=%h reset_mid_fill", txn, a);
        txn++;
        @(negedge clk);
        req = 1'b1; pc = a; flush = 1'b0; mem_valid = 1'b0;
        #4; chk("rst_ready", 32'(ready), 1);
        @(negedge clk);
        req = 1'b0;
        #4; chk("rst_fill_mem_req", 32'(mem_req), 1);
        @(negedge clk);
        reset = 1'b0;
        m_valid = 1'b0; m_tag = '0; m_line = '0; m_hits = 0; m_misses = 0;
        #4; chk_reset_outs("in_reset");
        @(negedge clk);
        reset = 1'b1;
        #4; chk_reset_outs("released");
        @(negedge clk);
        mem_valid = 1'b1; mem_line = {$urandom, $urandom};
        #4; chk_reset_outs("late_mem_valid");
        @(negedge clk);
        mem_valid = 1'b0;
        #4; chk_reset_outs("after_late");
    endtask

    initial begin
        logic [15:0] a;
        int          r;
        reset = 1'b0; req = 1'b0; flush = 1'b0; mem_valid = 1'b0;
        pc = '0; mem_line = '0;
        m_valid = 1'b0; m_tag = '0; m_line = '0; m_hits = 0; m_misses = 0;
        #3;
        chk_reset_outs("reset_hold");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #4;
        chk_reset_outs("reset_release");

        // Miss with mem_valid on the last legal FILL cycle, then hits in the line.
        fetch(16'h0002, 3, 0, 64'h0401_250A_1281_2D1E);
        fetch(16'h0006, 0, 0, 64'h0);
        fetch(16'h0000, 0, 0, 64'h0);
        fetch(16'h0004, 0, 0, 64'h0);
        chk("perf_hits_3", 32'(hit_count), PERF ? 3 : 0);
        chk("perf_miss_1", 32'(miss_count), PERF ? 1 : 0);
        // Line change.
        fetch(16'h0010, 1, 0, 64'h240A_0401_1281_2D1E);
        // Timeout, then the same pc must miss again.
        fetch(16'h0040, 0, 1, 64'h0);
        fetch(16'h0040, 0, 0, {$urandom, $urandom});
        // Flush in FILL with mem_valid in the same cycle, then re-fetch misses.
        fetch(16'h0080, 1, 2, {$urandom, $urandom});
        fetch(16'h0080, 2, 0, {$urandom, $urandom});
        fetch(16'h0082, 0, 3, 64'h0);
        flush_idle_req(16'h0084);
        reset_mid_fill(16'h0100);
        fetch(16'h0000, 0, 0, {$urandom, $urandom});

        for (int i = 0; i < 80; i++) begin
            a = {11'h000, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            r = int'($urandom_range(0, 15));
            if (r == 4) flush_idle_req(a);
            else fetch(a, int'($urandom_range(0, TO - 1)),
                       (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0,
                       {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) idle_noise();
        end

        @(negedge clk);
        mem_valid = 1'b0; req = 1'b0; flush = 1'b0;
        repeat (4) @(negedge clk);
        #4;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_responses actual=%0d pending required=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
